line_rotator_pingpong: RTL
==========================

Name: line_rotator_pingpong

Overview:
Parametrised successor of the single-mode line rotator. Double-buffers each BT.656 line in two banks and cuts/rotates the active-video part by a per-line DRBG cut position, in either scramble or descramble mode selected at run time. Sits between sync_parser and the output formatter. Takes its cut position from drbg_consumer.

Parameters:
DATA_WIDTH, 10, sample width (BT.656 word)
LINE_SIZE, 1716, maximum samples per line incl. blanking; sets bank depth
ACTIVE_SAMPLES, 1440, rotated region length (720 Y + 720 C)
CUT_WIDTH, 8, width of raw_cut_position
BLANK_VALUE, 10'h040, output for indices beyond the stored line length

Ports:
clk  in  1  sample clock
reset_n  in  1  asynchronous active-low reset
data_in  in  DATA_WIDTH  BT.656 sample
H  in  1  horizontal blanking flag from sync_parser
V  in  1  vertical blanking flag from sync_parser
raw_cut_position  in  CUT_WIDTH  DRBG cut value for the line starting now
mode  in  1  0 = scramble, 1 = descramble; sampled at line start
data_out  out  DATA_WIDTH  rotated sample, registered
data_valid  out  1  data_out carries a real delayed sample
line_short  out  1  one-cycle pulse: stored line was shorter than ACTIVE_SAMPLES

Behaviour:
- Reset (async, reset_n=0): data_out=0, data_valid=0, line_short=0, state=IDLE, write bank=0, counters=0. Asserting reset mid-line discards both banks.
- Line start: a cycle with H=0 whose previous cycle had H=1. That sample has index 0. The index increments per clock and saturates at LINE_SIZE-1; writes stop at saturation.
- At line start, latch the following for the line being written:
  - cut = (raw_cut_position * ACTIVE_SAMPLES) >> CUT_WIDTH. The product is CUT_WIDTH+11 bits. Range 0..1434 at defaults.
  - mode.
  - V. If V=1, force cut to 0.
- Also at line start: latch the previous line's final index+1 as its stored length, and swap banks.
- FSM:
  - IDLE goes to FILL on the first line start.
  - FILL goes to RUN on the next line start.
  - RUN stays in RUN.
  - Any state returns to IDLE only on reset.
- In RUN, read the previous bank at address r(k), where k is the current input index:
  - k < ACTIVE_SAMPLES, mode 0: r = (k + cut) mod ACTIVE_SAMPLES.
  - k < ACTIVE_SAMPLES, mode 1: r = (k + ACTIVE_SAMPLES - cut) mod ACTIVE_SAMPLES.
  - k >= ACTIVE_SAMPLES: r = k (blanking/EAV/SAV pass-through).
  - Modulo is a single conditional subtract. No divider.
- Latency: output for stored index k appears on data_out 2 clocks after input index k of the following line (1 RAM read + 1 output register). data_valid follows the same 2-cycle pipeline.
- Stored line shorter than ACTIVE_SAMPLES:
  - No rotation (r = k).
  - line_short pulses at the swap.
- k >= stored length: data_out = BLANK_VALUE, data_valid=0.
- Simultaneous line start and index saturation: line start wins; index resets to 0.
- In IDLE and FILL: data_valid=0, data_out holds 0.
- cut=0 in either mode gives identity. Scramble followed by descramble with the same cut is identity.

Optional Feature:
LINE_ROTATOR_STATS_EN
- Defined: adds outputs line_count (16-bit, increments at every line start in RUN, wraps) and short_count (8-bit, increments on each line_short, saturates at 255). Both reset to 0.
- Undefined: ports and logic absent. Core behaviour is identical either way.

Decomposition:
- Package line_rotator_pkg: mode encoding constants (MODE_SCRAMBLE=0, MODE_DESCRAMBLE=1), FSM state encoding (IDLE, FILL, RUN), default LINE_SIZE, ACTIVE_SAMPLES, BLANK_VALUE.
- Sub-module line_rotator_bank_ram: 2 x LINE_SIZE x DATA_WIDTH simple dual-port RAM.
  - Write port: bank select, address.
  - Read port: opposite bank, address.
  - Synchronous read, 1-cycle latency.
- Address mapping and FSM stay in the top.

Test Plan:
- Reset, then 2 lines of ramp data (sample = index), cut raw 0, mode 0 -> data_valid rises 2 clocks after second line start; output equals line 1 ramp exactly.
- raw_cut_position=128, mode 0, 1716-sample ramp lines -> cut=720; out[0]=720, out[719]=1439, out[720]=0, out[1440..1715] pass through.
- Chain two instances (mode 0 then mode 1) with identical per-line cut sequence 0,1,255,77 -> second output equals original stream, delayed by 2 lines + 4 clocks.
- V=1 during line start with raw=200 -> line passed unrotated; a following V=0 line with raw=200 rotates by 1125.
- Line truncated to 1000 samples -> line_short pulses once at next swap, data unrotated; indices 1000..1715 give BLANK_VALUE with data_valid=0.
- reset_n pulsed low mid-RUN -> outputs 0 immediately; data_valid stays 0 through one full FILL line after release.

Source files
------------

// File: rtl/line_rotator_pkg.sv
// Shared encodings and defaults for the ping-pong line rotator.
package line_rotator_pkg;
  localparam logic MODE_SCRAMBLE   = 1'b0;
  localparam logic MODE_DESCRAMBLE = 1'b1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  localparam int          DEF_LINE_SIZE      = 1716;
  localparam int          DEF_ACTIVE_SAMPLES = 1440;
  localparam logic [9:0]  DEF_BLANK_VALUE    = 10'h040;
endpackage

// File: rtl/line_rotator_bank_ram.sv
// Two line banks; write one bank while the opposite bank is read (1-cycle read latency).
module line_rotator_bank_ram #(
  parameter int DATA_WIDTH = 10,
  parameter int LINE_SIZE  = 1716,
  parameter int AW         = $clog2(LINE_SIZE)
)(
  input  logic                  clk,
  input  logic                  we,
  input  logic                  wr_bank,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2][LINE_SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_addr] <= wr_data;
    rd_data <= mem[~wr_bank][rd_addr];
  end
endmodule

// File: rtl/line_rotator_pingpong.sv
// Double-buffered BT.656 line rotator, scramble/descramble selected per line.
// Optional LINE_ROTATOR_STATS_EN adds line_count / short_count outputs.
module line_rotator_pingpong
  import line_rotator_pkg::*;
#(
  parameter int DATA_WIDTH     = 10,
  parameter int LINE_SIZE      = DEF_LINE_SIZE,
  parameter int ACTIVE_SAMPLES = DEF_ACTIVE_SAMPLES,
  parameter int CUT_WIDTH      = 8,
  parameter logic [DATA_WIDTH-1:0] BLANK_VALUE = DATA_WIDTH'(DEF_BLANK_VALUE)
)(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  H,
  input  logic                  V,
  input  logic [CUT_WIDTH-1:0]  raw_cut_position,
  input  logic                  mode,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  line_short
`ifdef LINE_ROTATOR_STATS_EN
 ,output logic [15:0]           line_count,
  output logic [7:0]            short_count
`endif
);
  localparam int AW  = $clog2(LINE_SIZE);
  localparam int LW  = $clog2(LINE_SIZE + 1);
  localparam int RW  = $clog2(2 * ACTIVE_SAMPLES);
  localparam int SW  = (LW > RW) ? LW : RW;
  localparam int PW  = CUT_WIDTH + 11;
  localparam logic [SW-1:0] ACT     = SW'(ACTIVE_SAMPLES);
  localparam logic [AW-1:0] IDX_MAX = AW'(LINE_SIZE - 1);

  state_t          state, state_nxt;
  logic            h_d, wr_bank, line_start, we, run_e, rd_vld, short_pulse;
  logic [AW-1:0]   idx, k, rd_addr, cut_new, cut_w, cut_r, cut_e;
  logic            mode_w, mode_r, mode_e;
  logic [LW-1:0]   len_r, len_new, len_e;
  logic [PW-1:0]   prod;
  logic [SW-1:0]   k_s, len_s, rd_sum;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]      vld_pipe;
  logic            run_q;

  assign line_start = h_d & ~H;
  assign k       = line_start ? '0 : ((idx == IDX_MAX) ? idx : idx + 1'b1);
  assign we      = line_start | (idx != IDX_MAX);
  assign prod    = PW'(raw_cut_position) * PW'(ACTIVE_SAMPLES);
  assign cut_new = V ? '0 : AW'(prod >> CUT_WIDTH);
  assign len_new = LW'(idx) + LW'(1);

  // At the line-start cycle the swap has not been registered yet, so read
  // with the parameters of the line that just finished.
  assign cut_e  = line_start ? cut_w   : cut_r;
  assign mode_e = line_start ? mode_w  : mode_r;
  assign len_e  = line_start ? len_new : len_r;
  assign run_e  = (state == RUN) | ((state == FILL) & line_start);
  assign k_s    = SW'(k);
  assign len_s  = SW'(len_e);
  assign rd_vld = run_e & (k_s < len_s);
  assign short_pulse = line_start & (state != IDLE) & (SW'(len_new) < ACT);

  always_comb begin
    rd_sum  = '0;
    rd_addr = k;
    if ((k_s < ACT) && (len_s >= ACT)) begin
      if (mode_e == MODE_DESCRAMBLE) rd_sum = k_s + ACT - SW'(cut_e);
      else                           rd_sum = k_s + SW'(cut_e);
      if (rd_sum >= ACT) rd_sum = rd_sum - ACT;
      rd_addr = AW'(rd_sum);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (line_start) state_nxt = FILL;
      FILL:    if (line_start) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      h_d        <= 1'b0;
      idx        <= '0;
      wr_bank    <= 1'b0;
      cut_w      <= '0;
      cut_r      <= '0;
      mode_w     <= MODE_SCRAMBLE;
      mode_r     <= MODE_SCRAMBLE;
      len_r      <= '0;
      vld_pipe   <= '0;
      run_q      <= 1'b0;
      data_out   <= '0;
      line_short <= 1'b0;
    end else begin
      state      <= state_nxt;
      h_d        <= H;
      idx        <= k;
      line_short <= short_pulse;
      if (line_start) begin
        wr_bank <= ~wr_bank;
        cut_w   <= cut_new;
        mode_w  <= mode;
        cut_r   <= cut_w;
        mode_r  <= mode_w;
        len_r   <= len_new;
      end
      vld_pipe <= {vld_pipe[0], rd_vld};
      run_q    <= run_e;
      if (!run_q)           data_out <= '0;
      else if (vld_pipe[0]) data_out <= rd_data;
      else                  data_out <= BLANK_VALUE;
    end
  end

  assign data_valid = vld_pipe[1];

  line_rotator_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_SIZE  (LINE_SIZE),
    .AW         (AW)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_bank (wr_bank ^ line_start),
    .wr_addr (k),
    .wr_data (data_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef LINE_ROTATOR_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_count  <= '0;
      short_count <= '0;
    end else begin
      if (line_start && state == RUN) line_count <= line_count + 16'd1;
      if (short_pulse && short_count != 8'hFF) short_count <= short_count + 8'd1;
    end
  end
`else
  // statistics counters not built
`endif
endmodule
